hrm_dump_scanner: RTL and testbench
===================================

Name: hrm_dump_scanner

Overview:
- Debug-side consumer of the CPU core's dump port (chip select, fifo position, dump data/valid).
- On request, walks PC, INSTR, REG, INBOX and OUTBOX, and serialises a framed byte stream over a valid/ready interface.
- The stream feeds the host-link transmitter, which drives the UART/screen view of the CPU state.
- Dump data from the core is combinational; this block owns all sequencing, settle cycles and back-pressure.

Parameters:
- FIFO_DEPTH, 32, maximum entries scanned per FIFO; matches the 5-bit dump position of the core FIFOs.
- HDR_BYTE, 8'hA5, frame header byte.
- TRL_BYTE, 8'h5A, frame trailer byte.

Ports:
- clk  in  1  system clock, all state on rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_start  in  1  pulse: begin a dump frame; ignored while o_busy.
- o_busy  out  1  high from the cycle after an accepted start until the trailer is transferred.
- o_done  out  1  one-cycle pulse on the cycle after the trailer transfer.
- o_dmp_chip_select  out  3  to core: 0=INBOX, 1=OUTBOX, 2=PC, 4=REG, 5=INSTR.
- o_dmp_fifo_pos  out  5  to core: FIFO position being read.
- i_dmp_data  in  8  from core: value at selected component/position.
- i_dmp_valid  in  1  from core: position valid (FIFO selects only).
- o_tx_data  out  8  stream byte.
- o_tx_valid  out  1  stream byte valid.
- i_tx_ready  in  1  sink accepts byte; transfer = o_tx_valid & i_tx_ready at a clock edge.
- o_incoherent  out  1  sticky: FIFO contents changed between count and send passes; cleared on accepted start.

Behaviour:
- Reset values:
  - o_busy=0, o_done=0, o_tx_valid=0, o_tx_data=0, o_dmp_chip_select=2 (PC), o_dmp_fifo_pos=0, o_incoherent=0.
  - FSM in IDLE.
- Reset mid-frame:
  - Frame abandoned; o_tx_valid low from the next edge.
  - No trailer; no o_done pulse.
- Frame order (fixed):
  - HDR_BYTE, PC, INSTR, REG.
  - INBOX count N, then N INBOX entries (pos 0..N-1).
  - OUTBOX count M, then M OUTBOX entries.
  - [checksum], TRL_BYTE.
  - With both FIFOs empty, the frame is 7 bytes.
- FSM states: IDLE, HDR, SEL, SETTLE, EMIT, CNT, CNT_EMIT, TRL, DONE.
  - IDLE -> HDR on i_start. The header is presented on the cycle after the start edge.
  - SEL drives select/pos registers. SETTLE waits exactly one cycle. EMIT then latches i_dmp_data into o_tx_data and asserts o_tx_valid.
  - CNT starts with pos=0 and increments one position per cycle while i_dmp_valid=1. It stops at the first invalid position or after FIFO_DEPTH positions. The count width is 6 bits, so 32 entries yields a count byte of 8'h20.
  - Each position sampled in CNT also gets its own SETTLE cycle, i.e. 2 cycles per position.
  - CNT_EMIT sends the count. It is followed by N SEL/SETTLE/EMIT rounds over pos 0..N-1. A count of 0 skips directly to the next section.
  - TRL sends TRL_BYTE. DONE pulses o_done for one cycle, then returns to IDLE.
- Stream handshake:
  - Once o_tx_valid rises, o_tx_data and o_tx_valid hold stable until transfer.
  - o_tx_valid never depends combinationally on i_tx_ready.
  - Next byte is presented no earlier than the cycle after transfer; no back-to-back throughput requirement.
- Coherence:
  - If i_dmp_valid=0 at an EMIT of a FIFO entry, the byte is sent anyway (current i_dmp_data) and o_incoherent is set.
  - Entry count sent always equals the count byte.
- i_start while busy: ignored, no queuing.
- o_dmp_fifo_pos returns to 0 on leaving each FIFO section.

Optional Feature:
- Macro: DUMP_CHECKSUM_EN.
- Defined:
  - An 8-bit XOR accumulator covers every transferred byte from HDR_BYTE through the last OUTBOX entry.
  - Its value is sent as one extra byte immediately before TRL_BYTE.
  - The accumulator clears on accepted start.
- Undefined: no checksum byte; TRL follows the last OUTBOX section directly, and the accumulator logic is absent.

Test Plan:
- Empty FIFOs, PC=8'h03, INSTR=8'h20, REG=8'h07, ready tied 1, start -> stream A5,03,20,07,00,00,5A; o_done one cycle after 5A; o_incoherent=0.
- INBOX holds 11,22,33 and OUTBOX holds 44 -> A5,PC,INSTR,REG,03,11,22,33,01,44,5A.
- DUMP_CHECKSUM_EN with the previous case -> checksum byte equals the XOR of all preceding bytes, inserted before 5A.
- INBOX full (32 entries 0..31), OUTBOX empty -> INBOX count byte 20, then entries 00..1F in order.
- i_tx_ready toggling 1-of-3 cycles -> identical byte sequence; o_tx_data is stable whenever valid and not ready.
- i_rst asserted mid-INBOX section -> next cycle o_tx_valid=0, o_busy=0, no o_done. A new start then yields a complete frame from A5.
- i_dmp_valid forced 0 on entry 2 during the send pass with count 3 -> 3 entries still sent and o_incoherent=1 until the next start.

Source files
------------

// File: rtl/hrm_dump_scanner.sv
// rtl/hrm_dump_scanner.sv - walks the core dump port and serialises a framed byte stream
// Optional checksum byte before the trailer is enabled by defining DUMP_CHECKSUM_EN.
module hrm_dump_scanner #(
  parameter int         FIFO_DEPTH = 32,
  parameter logic [7:0] HDR_BYTE   = 8'hA5,
  parameter logic [7:0] TRL_BYTE   = 8'h5A
) (
  input  logic       clk,
  input  logic       i_rst,
  input  logic       i_start,
  output logic       o_busy,
  output logic       o_done,
  output logic [2:0] o_dmp_chip_select,
  output logic [4:0] o_dmp_fifo_pos,
  input  logic [7:0] i_dmp_data,
  input  logic       i_dmp_valid,
  output logic [7:0] o_tx_data,
  output logic       o_tx_valid,
  input  logic       i_tx_ready,
  output logic       o_incoherent
);
  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_SEL, S_SETTLE, S_EMIT, S_CNT, S_CNT_EMIT, S_TRL, S_DONE
  } state_t;

  localparam logic [2:0] SECT_PC    = 3'd0;
  localparam logic [2:0] SECT_INSTR = 3'd1;
  localparam logic [2:0] SECT_REG   = 3'd2;
  localparam logic [2:0] SECT_IN    = 3'd3;
  localparam logic [2:0] SECT_OUT   = 3'd4;
  localparam logic [5:0] LP_DEPTH   = 6'(FIFO_DEPTH);

  state_t     r_state, w_next, w_sect_done_next;
  logic [2:0] r_sect, r_sel, w_sel_code;
  logic       r_phase_cnt, r_busy, r_done, r_tx_valid, r_incoherent;
  logic [5:0] r_cnt, w_cnt_inc;
  logic [4:0] r_idx, r_pos;
  logic [7:0] r_tx_data, w_trl_byte;
  logic       w_xfer, w_fifo_sect, w_emit_last, w_trl_last, w_start_ok;

  assign w_xfer       = r_tx_valid & i_tx_ready;
  assign w_fifo_sect  = (r_sect == SECT_IN) || (r_sect == SECT_OUT);
  assign w_cnt_inc    = r_cnt + 6'd1;
  assign w_emit_last  = w_fifo_sect && (({1'b0, r_idx} + 6'd1) == r_cnt);
  assign w_start_ok   = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_sect_done_next = (r_sect == SECT_IN) ? S_SEL : S_TRL;

  always_comb begin
    w_sel_code = 3'd2;
    case (r_sect)
      SECT_PC:    w_sel_code = 3'd2;
      SECT_INSTR: w_sel_code = 3'd5;
      SECT_REG:   w_sel_code = 3'd4;
      SECT_IN:    w_sel_code = 3'd0;
      SECT_OUT:   w_sel_code = 3'd1;
      default:    w_sel_code = 3'd2;
    endcase
  end

`ifdef DUMP_CHECKSUM_EN
  logic [7:0] r_chk;
  logic       r_chk_sent;

  // The checksum goes out from TRL first; only the trailer itself is excluded from the XOR.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_chk      <= 8'h00;
      r_chk_sent <= 1'b0;
    end else if (w_start_ok) begin
      r_chk      <= 8'h00;
      r_chk_sent <= 1'b0;
    end else if (w_xfer) begin
      if (r_state == S_TRL) r_chk_sent <= 1'b1;
      else                  r_chk      <= r_chk ^ r_tx_data;
    end
  end

  assign w_trl_last = r_chk_sent;
  assign w_trl_byte = r_chk_sent ? TRL_BYTE : r_chk;
`else
  assign w_trl_last = 1'b1;
  assign w_trl_byte = TRL_BYTE;
`endif

  always_ff @(posedge clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: w_next = i_start ? S_HDR : S_IDLE;
      S_HDR:          if (w_xfer) w_next = S_SEL;
      S_SEL:          w_next = S_SETTLE;
      S_SETTLE:       w_next = r_phase_cnt ? S_CNT : S_EMIT;
      S_CNT:          w_next = (!i_dmp_valid || (w_cnt_inc == LP_DEPTH)) ? S_CNT_EMIT : S_SETTLE;
      S_CNT_EMIT:     if (w_xfer) w_next = (r_cnt == 6'd0) ? w_sect_done_next : S_SEL;
      S_EMIT:         if (w_xfer) w_next = w_emit_last ? w_sect_done_next : S_SEL;
      S_TRL:          if (w_xfer && w_trl_last) w_next = S_DONE;
      default:        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_tx_valid   <= 1'b0;
      r_tx_data    <= 8'h00;
      r_sel        <= 3'd2;
      r_pos        <= 5'd0;
      r_incoherent <= 1'b0;
      r_sect       <= SECT_PC;
      r_phase_cnt  <= 1'b0;
      r_cnt        <= 6'd0;
      r_idx        <= 5'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: if (i_start) begin
          r_busy       <= 1'b1;
          r_tx_valid   <= 1'b1;
          r_tx_data    <= HDR_BYTE;
          r_incoherent <= 1'b0;
          r_sect       <= SECT_PC;
          r_phase_cnt  <= 1'b0;
          r_cnt        <= 6'd0;
          r_idx        <= 5'd0;
        end
        S_HDR: if (w_xfer) r_tx_valid <= 1'b0;
        S_SEL: begin
          r_sel <= w_sel_code;
          r_pos <= r_phase_cnt ? 5'd0 : r_idx;
          if (r_phase_cnt) r_cnt <= 6'd0;
        end
        S_CNT: if (i_dmp_valid) begin
          r_cnt <= w_cnt_inc;
          if (w_cnt_inc != LP_DEPTH) r_pos <= r_pos + 5'd1;
        end
        S_CNT_EMIT: begin
          if (!r_tx_valid) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= {2'b00, r_cnt};
          end else if (w_xfer) begin
            r_tx_valid  <= 1'b0;
            r_phase_cnt <= 1'b0;
            r_idx       <= 5'd0;
            if (r_cnt == 6'd0) begin
              r_pos <= 5'd0;
              if (r_sect == SECT_IN) begin
                r_sect      <= SECT_OUT;
                r_phase_cnt <= 1'b1;
              end
            end
          end
        end
        S_EMIT: begin
          if (!r_tx_valid) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= i_dmp_data;
            if (w_fifo_sect && !i_dmp_valid) r_incoherent <= 1'b1;
          end else if (w_xfer) begin
            r_tx_valid <= 1'b0;
            if (!w_fifo_sect) begin
              r_sect <= r_sect + 3'd1;
              if (r_sect == SECT_REG) r_phase_cnt <= 1'b1;
            end else if (w_emit_last) begin
              r_pos <= 5'd0;
              if (r_sect == SECT_IN) begin
                r_sect      <= SECT_OUT;
                r_phase_cnt <= 1'b1;
              end
            end else begin
              r_idx <= r_idx + 5'd1;
            end
          end
        end
        S_TRL: begin
          if (!r_tx_valid) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= w_trl_byte;
          end else if (w_xfer) begin
            r_tx_valid <= 1'b0;
            if (w_trl_last) begin
              r_busy <= 1'b0;
              r_done <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy            = r_busy;
  assign o_done            = r_done;
  assign o_tx_valid        = r_tx_valid;
  assign o_tx_data         = r_tx_data;
  assign o_dmp_chip_select = r_sel;
  assign o_dmp_fifo_pos    = r_pos;
  assign o_incoherent      = r_incoherent;
endmodule

// File: tb/tb_hrm_dump_scanner.sv
// tb/tb_hrm_dump_scanner.sv - directed self-checking bench for hrm_dump_scanner
module tb_hrm_dump_scanner;
  logic       clk = 1'b0;
  logic       rst, start, tx_ready, dmp_valid;
  logic [7:0] dmp_data;
  logic       busy, done, tx_valid, incoh;
  logic [2:0] sel;
  logic [4:0] pos;
  logic [7:0] tx_data;

  always #5 clk = ~clk;

  hrm_dump_scanner dut (
    .clk(clk), .i_rst(rst), .i_start(start), .o_busy(busy), .o_done(done),
    .o_dmp_chip_select(sel), .o_dmp_fifo_pos(pos),
    .i_dmp_data(dmp_data), .i_dmp_valid(dmp_valid),
    .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
    .o_incoherent(incoh)
  );

  logic [7:0] m_pc, m_instr, m_reg;
  logic [7:0] m_in [32];
  logic [7:0] m_out[32];
  int         m_in_n, m_out_n;
  bit         force_en;
  int         force_pos;

  // Combinational model of the core dump port.
  always_comb begin
    dmp_data  = 8'h00;
    dmp_valid = 1'b0;
    case (sel)
      3'd0: begin
        dmp_data  = m_in[pos];
        dmp_valid = (int'(pos) < m_in_n) && !(force_en && int'(pos) == force_pos);
      end
      3'd1: begin
        dmp_data  = m_out[pos];
        dmp_valid = int'(pos) < m_out_n;
      end
      3'd2: dmp_data = m_pc;
      3'd4: dmp_data = m_reg;
      3'd5: dmp_data = m_instr;
      default: ;
    endcase
  end

  int pass_cnt  = 0;
  int check_cnt = 0;

  task automatic check(input string tag, input int got, input int exp);
    check_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  task automatic run_frame(input string t, input int ready_mode, input int force_after,
                           input int exp_incoh);
    int         cyc;
    bit         prev_hold, xfer_prev, done_seen;
    logic [7:0] prev_data;
    int         unstable, n;
    got_q.delete();
    force_en  = 1'b0;
    unstable  = 0;
    prev_hold = 1'b0;
    xfer_prev = 1'b0;
    done_seen = 1'b0;
    prev_data = 8'h00;
    cyc       = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check({t, "_busy"}, int'(busy), 1);
    check({t, "_incoh_clr"}, int'(incoh), 0);
    while (!done_seen && cyc < 3000) begin
      if (done) begin
        check({t, "_done_after_trl"}, int'(xfer_prev), 1);
        done_seen = 1'b1;
      end else begin
        if (prev_hold && (!tx_valid || tx_data != prev_data)) unstable++;
        tx_ready  = (ready_mode == 0) ? 1'b1 : (cyc % 3 == 0);
        xfer_prev = tx_valid && tx_ready;
        if (xfer_prev) got_q.push_back(tx_data);
        if (force_after >= 0 && got_q.size() >= force_after) force_en = 1'b1;
        prev_hold = tx_valid && !tx_ready;
        prev_data = tx_data;
        cyc++;
        @(negedge clk);
      end
    end
    check({t, "_done_seen"}, int'(done_seen), 1);
    @(negedge clk);
    check({t, "_done_len"}, int'(done), 0);
    check({t, "_idle_busy"}, int'(busy), 0);
    check({t, "_stable"}, unstable, 0);
    check({t, "_incoh"}, int'(incoh), exp_incoh);
    check({t, "_len"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_b%0d", t, i), int'(got_q[i]), int'(exp_q[i]));
    force_en = 1'b0;
    tx_ready = 1'b1;
  endtask

  task automatic load_small();
    m_in_n  = 3;
    m_in[0] = 8'h11; m_in[1] = 8'h22; m_in[2] = 8'h33;
    m_out_n = 1;
    m_out[0] = 8'h44;
    exp_q = '{8'hA5, 8'h03, 8'h20, 8'h07, 8'h03, 8'h11, 8'h22, 8'h33, 8'h01, 8'h44};
`ifdef DUMP_CHECKSUM_EN
    exp_q.push_back(8'hC7);
`endif
    exp_q.push_back(8'h5A);
  endtask

  initial begin
    int cyc, hits;
    m_pc = 8'h03; m_instr = 8'h20; m_reg = 8'h07;
    for (int i = 0; i < 32; i++) begin
      m_in[i]  = 8'hEE;
      m_out[i] = 8'hDD;
    end
    m_in_n = 0; m_out_n = 0; force_en = 1'b0; force_pos = 2;
    rst = 1'b1; start = 1'b0; tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_valid", int'(tx_valid), 0);
    check("rst_data", int'(tx_data), 0);
    check("rst_sel", int'(sel), 2);
    check("rst_pos", int'(pos), 0);
    check("rst_incoh", int'(incoh), 0);
    rst = 1'b0;
    @(negedge clk);

    exp_q = '{8'hA5, 8'h03, 8'h20, 8'h07, 8'h00, 8'h00};
`ifdef DUMP_CHECKSUM_EN
    exp_q.push_back(8'h81);
`endif
    exp_q.push_back(8'h5A);
    run_frame("empty", 0, -1, 0);

    load_small();
    run_frame("small", 0, -1, 0);
    check("small_pos_home", int'(pos), 0);

    m_in_n = 32; m_out_n = 0;
    for (int i = 0; i < 32; i++) m_in[i] = 8'(i);
    exp_q = '{8'hA5, 8'h03, 8'h20, 8'h07, 8'h20};
    for (int i = 0; i < 32; i++) exp_q.push_back(8'(i));
    exp_q.push_back(8'h00);
`ifdef DUMP_CHECKSUM_EN
    exp_q.push_back(8'hA1);
`endif
    exp_q.push_back(8'h5A);
    run_frame("full", 0, -1, 0);

    load_small();
    run_frame("slow", 1, -1, 0);

    // Abort inside the INBOX send pass after the first entry goes out.
    got_q.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (got_q.size() < 6 && cyc < 500) begin
      if (tx_valid && tx_ready) got_q.push_back(tx_data);
      cyc++;
      @(negedge clk);
    end
    check("abort_reached", got_q.size(), 6);
    check("abort_in_inbox", int'(sel), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_valid", int'(tx_valid), 0);
    check("abort_busy", int'(busy), 0);
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) hits++;
      @(negedge clk);
    end
    check("abort_no_done", hits, 0);
    run_frame("after_abort", 0, -1, 0);

    force_pos = 2;
    run_frame("incoh", 0, 5, 1);
    repeat (4) @(negedge clk);
    check("incoh_sticky", int'(incoh), 1);
    run_frame("recover", 0, -1, 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
